// File: rtl/copper_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : copper_fetch
//  Description : Read-side front end for copper instruction memory. Issues
//                paired reads to the even/odd 16-bit memory halves, absorbs
//                the one-cycle BRAM read latency, and presents 32-bit
//                instructions from a 2-entry prefetch buffer over valid/ready.
//                Restart and jump reload the PC and flush buffered and
//                in-flight fetches.
//  Revision    : 1.0 - initial release
// ============================================================================
module copper_fetch #(
  parameter int AWIDTH = 10
) (
  input  logic              clk,
  input  logic              reset_n_i,
  input  logic              en_i,
  input  logic              restart_i,
  input  logic              jump_i,
  input  logic [AWIDTH-1:0] jump_addr_i,
  output logic              even_rd_en_o,
  output logic              odd_rd_en_o,
  output logic [AWIDTH-1:0] rd_address_o,
  input  logic [15:0]       even_data_i,
  input  logic [15:0]       odd_data_i,
  output logic              instr_valid_o,
  output logic [31:0]       instr_o,
  output logic [AWIDTH-1:0] instr_pc_o,
  input  logic              instr_ready_i
);

  localparam logic [AWIDTH-1:0] c_pc_one = {{(AWIDTH-1){1'b0}}, 1'b1};

  // Program counter and the single outstanding read.
  logic [AWIDTH-1:0] r_pc;
  logic              r_inflight;
  logic [AWIDTH-1:0] r_inflight_pc;

  // Two-entry prefetch buffer: the head drives the executor outputs directly.
  logic              r_head_valid;
  logic [31:0]       r_head_data;
  logic [AWIDTH-1:0] r_head_pc;
  logic              r_tail_valid;
  logic [31:0]       r_tail_data;
  logic [AWIDTH-1:0] r_tail_pc;

  logic        w_pop;
  logic        w_flush;
  logic        w_issue;
  logic        w_wr;
  logic [31:0] w_wr_data;
  logic [1:0]  w_occ;

  // Issue decision: never let buffered + in-flight entries exceed two after
  // this cycle's pop, so the buffer can never overflow. Reset gates the
  // enable so the memory ports go quiet the moment reset asserts.
  always_comb begin
    w_pop     = r_head_valid && instr_ready_i;
    w_flush   = restart_i || jump_i;
    w_wr      = r_inflight;
    w_wr_data = {even_data_i, odd_data_i};
    w_occ     = {1'b0, r_head_valid} + {1'b0, r_tail_valid}
              + {1'b0, r_inflight}   - {1'b0, w_pop};
    w_issue   = reset_n_i && en_i && !w_flush && (w_occ < 2'd2);
  end

  assign even_rd_en_o  = w_issue;
  assign odd_rd_en_o   = w_issue;
  assign rd_address_o  = r_pc;
  assign instr_valid_o = r_head_valid;
  assign instr_o       = r_head_data;
  assign instr_pc_o    = r_head_pc;

  // PC: restart beats jump; otherwise advance (wrapping) on each issue.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_pc <= '0;
    end else if (restart_i) begin
      r_pc <= '0;
    end else if (jump_i) begin
      r_pc <= jump_addr_i;
    end else if (w_issue) begin
      r_pc <= r_pc + c_pc_one;
    end
  end

  // In-flight tracker: a flush drops any read whose data is still pending.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight <= w_issue && !w_flush;
      if (w_issue) begin
        r_inflight_pc <= r_pc;
      end
    end
  end

  // Prefetch buffer: pop shifts the tail forward, returning data fills the
  // first free slot. Payload registers hold their value when emptied.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_head_valid <= 1'b0;
      r_head_data  <= '0;
      r_head_pc    <= '0;
      r_tail_valid <= 1'b0;
      r_tail_data  <= '0;
      r_tail_pc    <= '0;
    end else if (w_flush) begin
      r_head_valid <= 1'b0;
      r_tail_valid <= 1'b0;
    end else if (w_pop) begin
      if (r_tail_valid) begin
        r_head_data  <= r_tail_data;
        r_head_pc    <= r_tail_pc;
        r_tail_valid <= w_wr;
        if (w_wr) begin
          r_tail_data <= w_wr_data;
          r_tail_pc   <= r_inflight_pc;
        end
      end else begin
        r_head_valid <= w_wr;
        if (w_wr) begin
          r_head_data <= w_wr_data;
          r_head_pc   <= r_inflight_pc;
        end
      end
    end else if (w_wr) begin
      if (!r_head_valid) begin
        r_head_valid <= 1'b1;
        r_head_data  <= w_wr_data;
        r_head_pc    <= r_inflight_pc;
      end else if (!r_tail_valid) begin
        r_tail_valid <= 1'b1;
        r_tail_data  <= w_wr_data;
        r_tail_pc    <= r_inflight_pc;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_copper_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_copper_fetch
//  Description : Directed self-checking bench for copper_fetch with a
//                registered-read BRAM model (even[i]=0x1000+i, odd[i]=0x2000+i).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_copper_fetch;

  localparam int AWIDTH = 10;

  logic              clk = 1'b0;
  logic              reset_n_i;
  logic              en_i;
  logic              restart_i;
  logic              jump_i;
  logic [AWIDTH-1:0] jump_addr_i;
  logic              even_rd_en_o;
  logic              odd_rd_en_o;
  logic [AWIDTH-1:0] rd_address_o;
  logic [15:0]       even_data_i;
  logic [15:0]       odd_data_i;
  logic              instr_valid_o;
  logic [31:0]       instr_o;
  logic [AWIDTH-1:0] instr_pc_o;
  logic              instr_ready_i;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem_even [0:(1<<AWIDTH)-1];
  logic [15:0] mem_odd  [0:(1<<AWIDTH)-1];

  copper_fetch #(.AWIDTH(AWIDTH)) dut (
    .clk           (clk),
    .reset_n_i     (reset_n_i),
    .en_i          (en_i),
    .restart_i     (restart_i),
    .jump_i        (jump_i),
    .jump_addr_i   (jump_addr_i),
    .even_rd_en_o  (even_rd_en_o),
    .odd_rd_en_o   (odd_rd_en_o),
    .rd_address_o  (rd_address_o),
    .even_data_i   (even_data_i),
    .odd_data_i    (odd_data_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i)
  );

  always #5 clk = ~clk;

  // Registered-read memory halves; data holds when not enabled.
  always @(posedge clk) begin
    if (even_rd_en_o) even_data_i <= mem_even[rd_address_o];
    if (odd_rd_en_o)  odd_data_i  <= mem_odd[rd_address_o];
  end

  function automatic logic [31:0] exp_instr(input logic [AWIDTH-1:0] p);
    logic [15:0] pe;
    pe = {6'd0, p};
    return {16'h1000 + pe, 16'h2000 + pe};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n_i     = 1'b0;
    en_i          = 1'b0;
    restart_i     = 1'b0;
    jump_i        = 1'b0;
    jump_addr_i   = '0;
    instr_ready_i = 1'b0;
    tick;
    tick;
  endtask

  task automatic test_reset;
    do_reset;
    en_i = 1'b1;
    instr_ready_i = 1'b1;
    tick;
    total++; if (instr_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", instr_valid_o); end
    total++; if (instr_o !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 0", instr_o); end
    total++; if (instr_pc_o !== 10'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", instr_pc_o); end
    total++; if (even_rd_en_o !== 1'b0 || odd_rd_en_o !== 1'b0) begin bad++; $display("FAIL reset_rden: got %b%b want 00", even_rd_en_o, odd_rd_en_o); end
    total++; if (rd_address_o !== 10'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", rd_address_o); end
  endtask

  task automatic test_latency;
    do_reset;
    en_i = 1'b1;
    instr_ready_i = 1'b1;
    reset_n_i = 1'b1;
    #1;
    total++; if (even_rd_en_o !== 1'b1 || odd_rd_en_o !== 1'b1 || rd_address_o !== 10'h0) begin bad++; $display("FAIL lat_issue0: got en=%b%b addr=%h want 11/000", even_rd_en_o, odd_rd_en_o, rd_address_o); end
    total++; if (instr_valid_o !== 1'b0) begin bad++; $display("FAIL lat_c0_valid: got %b want 0", instr_valid_o); end
    tick;
    total++; if (instr_valid_o !== 1'b0 || rd_address_o !== 10'h1) begin bad++; $display("FAIL lat_c1: got valid=%b addr=%h want 0/001", instr_valid_o, rd_address_o); end
    tick;
    total++; if (instr_valid_o !== 1'b1 || instr_o !== 32'h10002000 || instr_pc_o !== 10'h0) begin bad++; $display("FAIL lat_c2: got v=%b i=%h pc=%h want 1/10002000/000", instr_valid_o, instr_o, instr_pc_o); end
    for (int i = 1; i <= 2; i++) begin
      tick;
      total++; if (instr_valid_o !== 1'b1 || instr_o !== exp_instr(i[AWIDTH-1:0]) || instr_pc_o !== i[AWIDTH-1:0]) begin bad++; $display("FAIL lat_stream%0d: got v=%b i=%h pc=%h want 1/%h/%h", i, instr_valid_o, instr_o, instr_pc_o, exp_instr(i[AWIDTH-1:0]), i[AWIDTH-1:0]); end
    end
  endtask

  task automatic test_backpressure;
    int n;
    logic [AWIDTH-1:0] addrs [0:1];
    n = 0;
    addrs[0] = '1;
    addrs[1] = '1;
    do_reset;
    en_i = 1'b1;
    instr_ready_i = 1'b0;
    reset_n_i = 1'b1;
    #1;
    for (int c = 0; c < 6; c++) begin
      if (even_rd_en_o) begin
        if (n < 2) addrs[n] = rd_address_o;
        n++;
      end
      tick;
    end
    total++; if (n !== 2) begin bad++; $display("FAIL bp_issue_count: got %0d want 2", n); end
    total++; if (addrs[0] !== 10'h0 || addrs[1] !== 10'h1) begin bad++; $display("FAIL bp_issue_addrs: got %h,%h want 000,001", addrs[0], addrs[1]); end
    total++; if (even_rd_en_o !== 1'b0) begin bad++; $display("FAIL bp_stalled: got %b want 0", even_rd_en_o); end
    instr_ready_i = 1'b1;
    #1;
    total++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 10'h0 || instr_o !== 32'h10002000) begin bad++; $display("FAIL bp_head0: got v=%b pc=%h i=%h want 1/000/10002000", instr_valid_o, instr_pc_o, instr_o); end
    total++; if (even_rd_en_o !== 1'b1 || rd_address_o !== 10'h2) begin bad++; $display("FAIL bp_resume: got en=%b addr=%h want 1/002", even_rd_en_o, rd_address_o); end
    for (int i = 1; i <= 3; i++) begin
      tick;
      total++; if (instr_valid_o !== 1'b1 || instr_pc_o !== i[AWIDTH-1:0] || instr_o !== exp_instr(i[AWIDTH-1:0])) begin bad++; $display("FAIL bp_drain%0d: got v=%b pc=%h i=%h want 1/%h", i, instr_valid_o, instr_pc_o, instr_o, i[AWIDTH-1:0]); end
    end
  endtask

  task automatic test_jump;
    do_reset;
    en_i = 1'b1;
    instr_ready_i = 1'b0;
    reset_n_i = 1'b1;
    #1;
    tick;
    tick;
    // Head holds pc 0, pc 1 is in flight.
    jump_i = 1'b1;
    jump_addr_i = 10'h3F0;
    #1;
    total++; if (even_rd_en_o !== 1'b0) begin bad++; $display("FAIL jump_n_noissue: got %b want 0", even_rd_en_o); end
    tick;
    jump_i = 1'b0;
    instr_ready_i = 1'b1;
    #1;
    total++; if (instr_valid_o !== 1'b0 || even_rd_en_o !== 1'b1 || rd_address_o !== 10'h3F0) begin bad++; $display("FAIL jump_n1: got v=%b en=%b addr=%h want 0/1/3f0", instr_valid_o, even_rd_en_o, rd_address_o); end
    tick;
    total++; if (instr_valid_o !== 1'b0) begin bad++; $display("FAIL jump_n2_valid: got %b want 0", instr_valid_o); end
    tick;
    total++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 10'h3F0 || instr_o !== 32'h13F023F0) begin bad++; $display("FAIL jump_n3: got v=%b pc=%h i=%h want 1/3f0/13f023f0", instr_valid_o, instr_pc_o, instr_o); end
    tick;
    total++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 10'h3F1) begin bad++; $display("FAIL jump_n4: got v=%b pc=%h want 1/3f1", instr_valid_o, instr_pc_o); end
  endtask

  task automatic test_wrap;
    logic [AWIDTH-1:0] exp_pc [0:3];
    exp_pc[0] = 10'h3FE;
    exp_pc[1] = 10'h3FF;
    exp_pc[2] = 10'h000;
    exp_pc[3] = 10'h001;
    do_reset;
    en_i = 1'b1;
    instr_ready_i = 1'b1;
    reset_n_i = 1'b1;
    tick;
    tick;
    tick;
    jump_i = 1'b1;
    jump_addr_i = 10'h3FE;
    tick;
    jump_i = 1'b0;
    #1;
    total++; if (rd_address_o !== 10'h3FE) begin bad++; $display("FAIL wrap_addr: got %h want 3fe", rd_address_o); end
    tick;
    for (int i = 0; i < 4; i++) begin
      tick;
      total++; if (instr_valid_o !== 1'b1 || instr_pc_o !== exp_pc[i] || instr_o !== exp_instr(exp_pc[i])) begin bad++; $display("FAIL wrap_seq%0d: got v=%b pc=%h i=%h want 1/%h/%h", i, instr_valid_o, instr_pc_o, instr_o, exp_pc[i], exp_instr(exp_pc[i])); end
    end
  endtask

  task automatic test_restart_jump;
    do_reset;
    en_i = 1'b1;
    instr_ready_i = 1'b1;
    reset_n_i = 1'b1;
    tick;
    tick;
    tick;
    restart_i = 1'b1;
    jump_i = 1'b1;
    jump_addr_i = 10'h100;
    #1;
    total++; if (even_rd_en_o !== 1'b0) begin bad++; $display("FAIL rj_noissue: got %b want 0", even_rd_en_o); end
    tick;
    restart_i = 1'b0;
    jump_i = 1'b0;
    #1;
    total++; if (even_rd_en_o !== 1'b1 || rd_address_o !== 10'h0) begin bad++; $display("FAIL rj_addr: got en=%b addr=%h want 1/000", even_rd_en_o, rd_address_o); end
    tick;
    total++; if (instr_valid_o !== 1'b0) begin bad++; $display("FAIL rj_n2_valid: got %b want 0", instr_valid_o); end
    tick;
    total++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 10'h0 || instr_o !== 32'h10002000) begin bad++; $display("FAIL rj_first: got v=%b pc=%h i=%h want 1/000/10002000", instr_valid_o, instr_pc_o, instr_o); end
    tick;
    // Asynchronous reset mid-cycle, well away from any clock edge.
    #2;
    reset_n_i = 1'b0;
    #1;
    total++; if (instr_valid_o !== 1'b0 || instr_o !== 32'h0 || instr_pc_o !== 10'h0) begin bad++; $display("FAIL async_rst_out: got v=%b i=%h pc=%h want 0/0/0", instr_valid_o, instr_o, instr_pc_o); end
    total++; if (even_rd_en_o !== 1'b0 || odd_rd_en_o !== 1'b0 || rd_address_o !== 10'h0) begin bad++; $display("FAIL async_rst_rd: got en=%b%b addr=%h want 00/000", even_rd_en_o, odd_rd_en_o, rd_address_o); end
  endtask

  task automatic test_enable;
    logic [AWIDTH-1:0] last_pc;
    do_reset;
    en_i = 1'b1;
    instr_ready_i = 1'b1;
    reset_n_i = 1'b1;
    #1;
    repeat (6) tick;
    en_i = 1'b0;
    #1;
    total++; if (even_rd_en_o !== 1'b0 || rd_address_o !== 10'h6) begin bad++; $display("FAIL en_off_issue: got en=%b addr=%h want 0/006", even_rd_en_o, rd_address_o); end
    total++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 10'h4) begin bad++; $display("FAIL en_off_head: got v=%b pc=%h want 1/004", instr_valid_o, instr_pc_o); end
    tick;
    total++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 10'h5 || instr_o !== 32'h10052005) begin bad++; $display("FAIL en_off_inflight: got v=%b pc=%h i=%h want 1/005/10052005", instr_valid_o, instr_pc_o, instr_o); end
    last_pc = instr_pc_o;
    for (int i = 2; i <= 4; i++) begin
      tick;
      total++; if (instr_valid_o !== 1'b0 || rd_address_o !== 10'h6) begin bad++; $display("FAIL en_off_idle%0d: got v=%b addr=%h want 0/006", i, instr_valid_o, rd_address_o); end
    end
    tick;
    en_i = 1'b1;
    #1;
    total++; if (even_rd_en_o !== 1'b1 || rd_address_o !== 10'h6) begin bad++; $display("FAIL en_on_issue: got en=%b addr=%h want 1/006", even_rd_en_o, rd_address_o); end
    tick;
    tick;
    total++; if (instr_valid_o !== 1'b1 || instr_pc_o !== last_pc + 10'h1 || instr_o !== 32'h10062006) begin bad++; $display("FAIL en_on_next: got v=%b pc=%h i=%h want 1/006/10062006", instr_valid_o, instr_pc_o, instr_o); end
  endtask

  initial begin
    for (int i = 0; i < (1 << AWIDTH); i++) begin
      mem_even[i] = 16'h1000 + i[15:0];
      mem_odd[i]  = 16'h2000 + i[15:0];
    end
    even_data_i = 16'h0;
    odd_data_i  = 16'h0;
    test_reset;
    test_latency;
    test_backpressure;
    test_jump;
    test_wrap;
    test_restart_jump;
    test_enable;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Buffer occupancy plus the outstanding read must never exceed two.
  always @(negedge clk) begin
    if (reset_n_i) begin
      assert (!(dut.r_head_valid && dut.r_tail_valid && dut.r_inflight))
        else $error("buffer overflow condition");
    end
  end

endmodule
`default_nettype wire
